// File: rtl/sobel_pkg.sv
// Shared widths, reset constants and small arithmetic helpers for the Sobel edge detector.
package sobel_pkg;
    localparam int PIX_W    = 8;
    localparam int GRAD_W   = 11;
    localparam int MAG_W    = 11;
    localparam int PIPE_LAT = 4;
    localparam int SUM_W    = PIX_W + 2;
    localparam logic [PIX_W-1:0] THRESH_RST = 8'd128;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic [SUM_W-1:0]         sum_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [MAG_W-1:0]         mag_t;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    // One Sobel tap column/row: a + 2b + c.
    function automatic sum_t wsum(input pix_t a, input pix_t b, input pix_t c);
        return sum_t'(a) + sum_t'({b, 1'b0}) + sum_t'(c);
    endfunction

    function automatic mag_t abs_grad(input grad_t g);
        return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
    endfunction
endpackage

// File: rtl/sobel_edge_detect_if.sv
// Video stream bundle: pre_* from the upstream pixel source, post_* toward the display path.
interface sobel_edge_detect_if;
    import sobel_pkg::*;

    logic pre_frame_vsync;
    logic pre_frame_href;
    logic pre_frame_clken;
    pix_t pre_img_y;
    logic post_frame_vsync;
    logic post_frame_href;
    logic post_frame_clken;
    logic post_img_bit;

    modport master (
        output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_y,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_y,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// Single-port line memory with asynchronous read; read returns the old word on a same-address write.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 4-stage |Gx|+|Gy| pipeline,
// per-frame threshold and border masking; sync signals delayed to match.
module sobel_edge_detect
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 10
) (
    input  logic              clk_pixel_division,
    input  logic              rst_n,
    input  logic [PIX_W-1:0]  threshold,
    sobel_edge_detect_if.slave vid
);
    logic accept;
    assign accept = vid.pre_frame_href & vid.pre_frame_clken;

    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic             href_prev_q, vsync_prev_q, frame_ok_q;
    pix_t             thr_q;

    always_comb begin
        col_d = col_q;
        if (!vid.pre_frame_href) col_d = '0;
        else if (vid.pre_frame_clken && col_q != COL_W'(IMG_WIDTH - 1)) col_d = col_q + 1'b1;

        row_d = row_q;
        if (vid.pre_frame_vsync) row_d = '0;
        else if (href_prev_q && !vid.pre_frame_href && row_q != 2'd3) row_d = row_q + 1'b1;
    end

    // frame_ok_q keeps output masked after a reset until a fresh frame has started.
    always_ff @(posedge clk_pixel_division or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            thr_q        <= THRESH_RST;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            href_prev_q  <= vid.pre_frame_href;
            vsync_prev_q <= vid.pre_frame_vsync;
            if (vid.pre_frame_vsync) frame_ok_q <= 1'b1;
            if (vid.pre_frame_vsync && !vsync_prev_q) thr_q <= threshold;
        end
    end

    pix_t lb1_rd, lb2_rd;

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_lb1 (
        .clk_i   (clk_pixel_division),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (vid.pre_img_y),
        .rdata_o (lb1_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_lb2 (
        .clk_i   (clk_pixel_division),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb1_rd),
        .rdata_o (lb2_rd)
    );

    // win_q[row][col]: row 0 is two lines up, col 2 is the newest column.
    pix_t  win_q [3][3];
    logic  s1_valid_q, s2_valid_q, s3_valid_q, bit_q;
    grad_t gx_q, gy_q;
    mag_t  mag_q;
    sync_t sync_q [PIPE_LAT];

    always_ff @(posedge clk_pixel_division or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
            for (int i = 0; i < PIPE_LAT; i++) sync_q[i] <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
            mag_q      <= '0;
            bit_q      <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb2_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= vid.pre_img_y;
                s1_valid_q  <= frame_ok_q && (row_q >= 2'd2) && (col_q >= COL_W'(2));
            end

            gx_q <= grad_t'({1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])}
                          - {1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])});
            gy_q <= grad_t'({1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])}
                          - {1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])});
            s2_valid_q <= s1_valid_q;

            mag_q      <= abs_grad(gx_q) + abs_grad(gy_q);
            s3_valid_q <= s2_valid_q;

            // sync_q[PIPE_LAT-2] is the stage that becomes post_* on this same edge.
            bit_q <= s3_valid_q && (mag_q > MAG_W'(thr_q))
                     && sync_q[PIPE_LAT-2].href && sync_q[PIPE_LAT-2].clken;

            sync_q[0] <= {vid.pre_frame_vsync, vid.pre_frame_href, vid.pre_frame_clken};
            for (int i = 1; i < PIPE_LAT; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign vid.post_frame_vsync = sync_q[PIPE_LAT-1].vsync;
    assign vid.post_frame_href  = sync_q[PIPE_LAT-1].href;
    assign vid.post_frame_clken = sync_q[PIPE_LAT-1].clken;
    assign vid.post_img_bit     = bit_q;
endmodule

// File: tb/tb_sobel_edge_detect.sv
// Scoreboard bench for sobel_edge_detect on a small 8x6 image with an image-coordinate reference model.
module tb_sobel_edge_detect;
    localparam int W = 8;
    localparam int H = 6;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] threshold = 8'd0;

    sobel_edge_detect_if bus();

    sobel_edge_detect #(.IMG_WIDTH(W), .COL_W(3)) dut (
        .clk_pixel_division (clk),
        .rst_n              (rst_n),
        .threshold          (threshold),
        .vid                (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    bit exp_q [$];
    int img [H][W];
    logic [2:0] hist [LAT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Sobel at window centre (r-1, c-1) for the pixel accepted at (r, c).
    function automatic bit ref_bit(input int r, input int c, input int thr);
        int gx, gy, mag;
        if (r < 2 || c < 2) return 1'b0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
           - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return mag > thr;
    endfunction

    // Input sync as sampled by the DUT, aged one clock per slot.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) hist[i] <= 3'b0;
        end else begin
            hist[0] <= {bus.pre_frame_vsync, bus.pre_frame_href, bus.pre_frame_clken};
            for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
        end
    end

    always @(negedge clk) begin
        bit e;
        if (!rst_n) begin
            chk("reset_outputs", {bus.post_frame_vsync, bus.post_frame_href,
                                  bus.post_frame_clken, bus.post_img_bit}, 4'b0);
        end else begin
            chk("sync_delay", {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken},
                hist[LAT-1]);
            if (bus.post_frame_href && bus.post_frame_clken) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL edge_bit: output pixel with empty scoreboard, got %0b at %0t",
                             bus.post_img_bit, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_bit", bus.post_img_bit, e);
                end
            end else begin
                chk("bit_gated", bus.post_img_bit, 1'b0);
            end
        end
    end

    task automatic drive(input bit vs, input bit hr, input bit ce, input int y);
        @(posedge clk);
        #1;
        bus.pre_frame_vsync = vs;
        bus.pre_frame_href  = hr;
        bus.pre_frame_clken = ce;
        bus.pre_img_y       = 8'(y);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_async", {bus.post_frame_vsync, bus.post_frame_href,
                            bus.post_frame_clken, bus.post_img_bit}, 4'b0);
        bus.pre_frame_vsync = 1'b0;
        bus.pre_frame_href  = 1'b0;
        bus.pre_frame_clken = 1'b0;
        bus.pre_img_y       = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill_uniform(input int v);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
    endtask

    task automatic fill_step(input int lo, input int hi);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? lo : hi;
    endtask

    task automatic fill_random(input int maxv);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, maxv));
    endtask

    // thr_vs is what the frame uses; thr_mid is presented from the middle row on.
    task automatic run_frame(input int thr_vs, input int thr_mid, input int gap_pct, input int rst_at);
        threshold = 8'(thr_vs);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int gaps;
                if (r == H/2 && c == 0) threshold = 8'(thr_mid);
                if (r*W + c == rst_at) begin
                    do_reset();
                    return;
                end
                gaps = 0;
                while (gaps < 12 && int'($urandom_range(0, 99)) < gap_pct) begin
                    drive(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 255)));
                    gaps++;
                end
                drive(1'b0, 1'b1, 1'b1, img[r][c]);
                exp_q.push_back(ref_bit(r, c, thr_vs));
            end
            for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 0);
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.pre_frame_vsync = 1'b0;
        bus.pre_frame_href  = 1'b0;
        bus.pre_frame_clken = 1'b0;
        bus.pre_img_y       = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 0);

        fill_uniform(100);   run_frame(128, 128, 0, -1);
        fill_step(0, 255);   run_frame(128, 128, 0, -1);
        fill_step(0, 20);    run_frame(70, 70, 0, -1);
                             run_frame(80, 80, 0, -1);
                             run_frame(79, 79, 0, -1);
        // Mid-frame drop to 0 must not unmask the weak step until the next frame.
        fill_step(0, 20);    run_frame(128, 0, 0, -1);
        fill_uniform(100);   run_frame(0, 0, 0, -1);
        fill_random(255);    run_frame(int'($urandom_range(0, 255)), 40, 0, 3*W + 5);
        fill_step(0, 255);   run_frame(128, 128, 0, -1);
        fill_step(0, 255);   run_frame(128, 128, 30, -1);
        for (int k = 0; k < 6; k++) begin
            fill_random(40);
            run_frame(int'($urandom_range(0, 200)), int'($urandom_range(0, 255)), 30, -1);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sobel_edge_detect.md
# sobel_edge_detect

Streaming Sobel edge detector that sits directly downstream of the threshold-adjust block and consumes its `threshold` output. It takes an 8-bit grayscale pixel stream in the `clk_pixel_division` domain. Two internal line buffers form a 3×3 window, and the block computes |Gx|+|Gy|. It outputs a 1-bit edge map with sync/enable signals delayed to match, for the downstream display/binarisation path.

## Interface
- `IMG_WIDTH`, default 640: active pixels per line; sets line-buffer depth.
- `COL_W`, default 10: column counter width, ≥ clog2(IMG_WIDTH).
- `clk_pixel_division`, input, 1 bit: pixel clock (OV5640 PCLK/2). This is the only clock.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `threshold`, input, 8 bits: edge threshold from the adjust block, same clock domain.
- `pre_frame_vsync`, input, 1 bit: frame sync, active-high.
- `pre_frame_href`, input, 1 bit: line-valid, active-high.
- `pre_frame_clken`, input, 1 bit: pixel-valid strobe, only meaningful while `href`=1.
- `pre_img_y`, input, 8 bits: grayscale pixel.
- `post_frame_vsync`, output, 1 bit: `pre_frame_vsync` delayed by 4 clocks.
- `post_frame_href`, output, 1 bit: `pre_frame_href` delayed by 4 clocks.
- `post_frame_clken`, output, 1 bit: `pre_frame_clken` delayed by 4 clocks.
- `post_img_bit`, output, 1 bit: 1 = edge, 0 = non-edge.

## Operation
- **Column counter:** increments on each `clken` while `href`=1. Cleared while `href`=0. It saturates at IMG_WIDTH-1; extra pixels overwrite the last buffer slot.
- **Row counter:** increments on the `href` falling edge and saturates at 3. Cleared while `vsync`=1.
- **Line buffers:** two, each IMG_WIDTH×8. On each `clken`:
  - LB1[col] is read as the pixel one row up, and LB2[col] as the pixel two rows up.
  - Write LB1[col] ← `pre_img_y` and LB2[col] ← old LB1[col].
  - Read-before-write at the same address.
- **Window:** a 3×3 register window (p11..p33, p33 = newest). On each `clken`, columns shift left and the new column {LB2 out, LB1 out, `pre_img_y`} enters on the right. The window holds its value when `clken`=0.
- **Gradients:**
  - Gx = (p13 + 2·p23 + p33) − (p11 + 2·p21 + p31).
  - Gy = (p11 + 2·p12 + p13) − (p31 + 2·p32 + p33).
  - Both are 11-bit signed, range ±1020.
- **Magnitude:** mag = |Gx| + |Gy|, 11-bit unsigned, max 2040. No saturation is needed.
- **Decision:** edge = (mag > {3'b0, thr_frame}), a strict compare.
- **Threshold sampling:** `thr_frame` is an 8-bit register loaded from `threshold` on the `pre_frame_vsync` rising edge only. A threshold change mid-frame takes effect from the next frame.
- **Border handling:** `post_img_bit` is forced to 0 when the window is incomplete. This covers row < 2 or col < 2 at the time the pixel was accepted. The flag is captured in stage 1 and carried through the pipeline.
- **Geometry:** the output pixel is the window centre, so the edge map is offset one row and one column up-left. This offset is accepted and not compensated.
- **Gating:** `post_img_bit` is 0 whenever `post_frame_href`=0 or `post_frame_clken`=0.

## Timing
- **Pipeline stages** (all free-running per clock):
  - S1: window/border capture on `clken`.
  - S2: partial sums.
  - S3: abs + add.
  - S4: compare → `post_img_bit`.
- **Latency:** fixed 4 clocks from an input `clken` to its `post_frame_clken`. vsync/href/clken pass through a 4-deep shift register.
- **Reset values:**
  - All `post_*` outputs = 0.
  - `thr_frame` = 8'd128.
  - Counters = 0.
  - Window registers = 0.
  - Line-buffer contents are don't-care, since border masking covers the first two rows.
- **Reset mid-frame:** outputs drop to 0 asynchronously. After release, output stays masked until the next vsync and two full rows have been received.
- **Back-to-back `clken`:** supported every cycle. Gaps of any length are allowed.
- **Simultaneous events:** `vsync` rising while `href`=1 is a protocol violation. Counters still clear.

## Structure
- **Shared package `sobel_pkg`:** `PIX_W`=8, `GRAD_W`=11, `MAG_W`=11, `PIPE_LAT`=4, `THRESH_RST`=8'd128.
- **Sub-module `sobel_line_buffer`:** parameterised depth/width, with one read-before-write port. It is instantiated twice. It infers BRAM or distributed RAM, with no reset on the memory.

## Test plan
- **Uniform frame:** 8×6 frame, all pixels 100, threshold 128 → `post_img_bit`=0 everywhere; `post_*` sync = input delayed exactly 4 clocks.
- **Strong vertical step:** cols 0–3 = 0, cols 4–7 = 255, threshold 128 → mag 1020 at the two centres straddling the step; bit=1 there in rows ≥2, 0 elsewhere; rows 0–1 and cols 0–1 are 0.
- **Weak step, strict compare:** 0→20 step gives mag 80. Threshold 70 → 1; threshold 80 → 0; threshold 79 → 1.
- **Threshold change mid-frame:** change threshold 128→0 mid-frame on a uniform image → no change until the next vsync. In the next frame, uniform interior stays 0 (mag 0 > 0 is false).
- **Reset mid-line:** assert `rst_n`=0 mid-line → outputs 0 within the same cycle. Next frame after release matches a clean run bit-for-bit.
- **Clken gaps:** random `clken` gaps (duty 30%) on the step image → output bit sequence is identical to the gap-free run.
